iot_filter_p: RTL and testbench

Parametrised IoT data filter, successor to the fixed 128-bit filter. It accepts a byte stream, assembles blocks of BLK_BYTES bytes and applies one of seven functions. Functions are pass-through, group max, group min, group average, CRC, binary-to-Gray and Gray-to-binary. It sits between the sensor byte interface and the 8*BLK_BYTES-bit result bus, with the same busy/valid handshake as the existing filter.

---
 rtl/iot_filter_p.sv | 184 ++++++++++++++++++
 tb/tb_iot_filter_p.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/iot_filter_p.sv
// iot_filter_p
//   Byte-stream block filter. Assembles BLK_BYTES bytes (MSB-first) into one
//   W = 8*BLK_BYTES bit block, then applies the latched function:
//     0 pass, 1 group max, 2 group min, 3 group average,
//     4 CRC, 5 binary->Gray, 6 Gray->binary, 7 reserved (block dropped).
//   Group functions (1-3) emit one result per 2^GRP_LOG2 blocks.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   in_en    byte strobe, honoured only while busy == 0
//   iot_in   data byte, first byte lands in W-1:W-8
//   fn_sel   function select, sampled on the first byte of a block/group
//   busy     registered; high while a block is processed and during IDLE
//   valid    registered one-cycle result strobe
//   iot_out  registered result, held between strobes
module iot_filter_p #(
  parameter int               BLK_BYTES = 16,
  parameter int               GRP_LOG2  = 3,
  parameter int               CRC_W     = 8,
  parameter logic [CRC_W-1:0] CRC_POLY  = 8'h07
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [7:0]             iot_in,
  input  logic [2:0]             fn_sel,
  output logic                   busy,
  output logic                   valid,
  output logic [8*BLK_BYTES-1:0] iot_out
);

  localparam int W  = 8 * BLK_BYTES;
  localparam int CW = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
  localparam int SW = W + GRP_LOG2;

  localparam logic [CW-1:0]       LAST_BYTE = CW'(BLK_BYTES - 1);
  localparam logic [GRP_LOG2-1:0] GRP_LAST  = '1;

  localparam logic [2:0] M_PASS = 3'd0;
  localparam logic [2:0] M_MAX  = 3'd1;
  localparam logic [2:0] M_MIN  = 3'd2;
  localparam logic [2:0] M_AVG  = 3'd3;
  localparam logic [2:0] M_CRC  = 3'd4;
  localparam logic [2:0] M_B2G  = 3'd5;
  localparam logic [2:0] M_G2B  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC, S_OUT} state_t;

  state_t                state, state_nxt;
  logic [W-1:0]          blk;
  logic [CW-1:0]         cnt;
  logic [2:0]            mode;
  logic [GRP_LOG2-1:0]   grp_cnt;
  logic [W-1:0]          acc;
  logic [SW-1:0]         sum;
  logic [CRC_W-1:0]      crc;

  logic                  take, is_grp, grp_last, proc_done, emit;
  logic [W-1:0]          acc_nxt, result, g2b;
  logic [SW-1:0]         sum_nxt;
  logic [CRC_W-1:0]      crc_nxt;

  // One byte through the CRC register, MSB first, non-reflected.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                input logic [7:0]       d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[CRC_W-1] ^ d[k];
      r  = (r << 1) ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  assign take      = (state == S_LOAD) && in_en && !busy;
  assign is_grp    = (mode == M_MAX) || (mode == M_MIN) || (mode == M_AVG);
  assign grp_last  = (grp_cnt == GRP_LAST);
  // CRC walks the block one byte per PROC cycle, reusing the byte counter.
  assign proc_done = (state == S_PROC) && ((mode != M_CRC) || (cnt == LAST_BYTE));
  assign crc_nxt   = crc_byte((cnt == '0) ? '0 : crc, blk[W-1 -: 8]);

  // Gray->binary: bit i is the parity of everything at or above it.
  for (genvar i = 0; i < W; i++) begin : g_g2b
    assign g2b[i] = ^blk[W-1:i];
  end

  always_comb begin
    acc_nxt = acc;
    if (grp_cnt == '0)       acc_nxt = blk;
    else if (mode == M_MAX)  acc_nxt = (blk > acc) ? blk : acc;
    else                     acc_nxt = (blk < acc) ? blk : acc;
    sum_nxt = ((grp_cnt == '0) ? '0 : sum) + SW'(blk);

    result = blk;
    emit   = 1'b0;
    case (mode)
      M_PASS:        begin result = blk;                    emit = 1'b1;     end
      M_MAX, M_MIN:  begin result = acc_nxt;                emit = grp_last; end
      M_AVG:         begin result = sum_nxt[SW-1:GRP_LOG2]; emit = grp_last; end
      M_CRC:         begin result = W'(crc_nxt);            emit = 1'b1;     end
      M_B2G:         begin result = blk ^ (blk >> 1);       emit = 1'b1;     end
      M_G2B:         begin result = g2b;                    emit = 1'b1;     end
      default:       begin result = blk;                    emit = 1'b0;     end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_LOAD;
      S_LOAD: if (take && (cnt == LAST_BYTE)) state_nxt = S_PROC;
      S_PROC: if (proc_done) state_nxt = S_OUT;
      S_OUT:  state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b1;
      valid   <= 1'b0;
      iot_out <= '0;
      blk     <= '0;
      cnt     <= '0;
      mode    <= M_PASS;
      grp_cnt <= '0;
      acc     <= '0;
      sum     <= '0;
      crc     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: busy <= 1'b0;
        S_LOAD: if (take) begin
          blk <= (blk << 8) | W'(iot_in);
          if (cnt == LAST_BYTE) begin
            cnt  <= '0;
            busy <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          // Mode is only re-sampled at a block boundary that is not inside
          // a running group, so a group always finishes in its own mode.
          if ((cnt == '0) && !(is_grp && (grp_cnt != '0))) begin
            mode <= fn_sel;
            if (fn_sel != mode) grp_cnt <= '0;
          end
        end
        S_PROC: begin
          if (mode == M_CRC) begin
            blk <= blk << 8;
            crc <= proc_done ? '0 : crc_nxt;
            cnt <= proc_done ? '0 : cnt + 1'b1;
          end
          if (is_grp) begin
            if (grp_last) begin
              grp_cnt <= '0;
              acc     <= '0;
              sum     <= '0;
            end else begin
              grp_cnt <= grp_cnt + 1'b1;
              acc     <= acc_nxt;
              sum     <= sum_nxt;
            end
          end
          if (proc_done && emit) begin
            valid   <= 1'b1;
            iot_out <= result;
          end
        end
        S_OUT: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iot_filter_p.sv
// Directed bench for iot_filter_p with default parameters (W = 128).
module tb_iot_filter_p;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst, in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy, valid;
  logic [W-1:0] iot_out;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_out;

  iot_filter_p dut (
    .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
    .busy(busy), .valid(valid), .iot_out(iot_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Feed one block, then hold in_en high with a junk byte and fn_sel=7 while
  // busy. Non-first bytes carry a changing fn_sel. Checks busy/valid at every
  // cycle from the last-byte edge T through T+p+1.
  task automatic run_block(input string tag, input logic [W-1:0] b, input logic [2:0] f,
                           input logic exp_v, input logic [W-1:0] exp_o,
                           input int p, input bit gap);
    int n;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (busy && n < 64) begin tick(); n++; end
      if (busy) chk1({tag, " busy_wait"}, busy, 1'b0);
      if (gap && i == 8) begin
        in_en = 1'b0;
        repeat (3) tick();
      end
      in_en  = 1'b1;
      iot_in = b[W-1-8*i -: 8];
      fn_sel = (i == 0) ? f : 3'(i);
      tick();
    end
    in_en  = 1'b1;
    iot_in = 8'hEE;
    fn_sel = 3'd7;
    chk1({tag, " busy_T"}, busy, 1'b1);
    chk1({tag, " valid_T"}, valid, 1'b0);
    for (int k = 1; k < p; k++) begin
      tick();
      chk1({tag, " valid_proc"}, valid, 1'b0);
    end
    tick();
    if (exp_v) last_out = exp_o;
    chk1({tag, " valid"}, valid, exp_v);
    chk({tag, " out"}, iot_out, last_out);
    chk1({tag, " busy_out"}, busy, 1'b1);
    tick();
    chk1({tag, " valid_after"}, valid, 1'b0);
    chk1({tag, " busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [7:0]   grp_v [8];
    ones  = '1;
    grp_v = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd1, 8'd2, 8'd8, 8'd7};

    // Reset state and IDLE->LOAD
    rst = 1'b1; in_en = 1'b0; iot_in = 8'h00; fn_sel = 3'd0;
    last_out = '0;
    repeat (3) tick();
    chk1("rst busy", busy, 1'b1);
    chk1("rst valid", valid, 1'b0);
    chk("rst out", iot_out, '0);
    rst = 1'b0;
    chk1("idle busy", busy, 1'b1);
    tick();
    chk1("load busy", busy, 1'b0);

    // Gray conversions
    run_block("b2g_3", 128'h3, 3'd5, 1'b1, 128'h2, 1, 1'b0);
    run_block("b2g_msb", {1'b1, 127'b0}, 3'd5, 1'b1, {2'b11, 126'b0}, 1, 1'b0);
    run_block("g2b_2", 128'h2, 3'd6, 1'b1, 128'h3, 1, 1'b0);

    // CRC-8 poly 0x07
    run_block("crc_01", 128'h1, 3'd4, 1'b1, 128'h07, 16, 1'b0);
    run_block("crc_00", 128'h0, 3'd4, 1'b1, 128'h00, 16, 1'b0);

    // Pass-through, one with an in_en gap, then reserved mode holds output
    run_block("pass_gap", 128'h0123456789ABCDEF_FEDCBA9876543210, 3'd0, 1'b1,
              128'h0123456789ABCDEF_FEDCBA9876543210, 1, 1'b1);
    run_block("pass_held", 128'hA5A5_0000_1111_2222_3333_4444_5555_5AA5, 3'd0, 1'b1,
              128'hA5A5_0000_1111_2222_3333_4444_5555_5AA5, 1, 1'b0);
    run_block("rsvd", 128'hDEAD_BEEF, 3'd7, 1'b0, '0, 1, 1'b0);

    // Group max then min
    for (int k = 0; k < 8; k++)
      run_block("max", W'(grp_v[k]), 3'd1, (k == 7), 128'h9, 1, 1'b0);
    for (int k = 0; k < 8; k++)
      run_block("min", W'(grp_v[k]), 3'd2, (k == 7), 128'h1, 1, 1'b0);

    // Group average
    for (int k = 0; k < 8; k++)
      run_block("avg_ones", ones, 3'd3, (k == 7), ones, 1, 1'b0);
    for (int k = 0; k < 8; k++)
      run_block("avg_1to8", W'(k + 1), 3'd3, (k == 7), 128'h4, 1, 1'b0);

    // Reset mid-group and mid-block
    for (int k = 0; k < 4; k++)
      run_block("pre_rst", 128'hF0, 3'd3, 1'b0, '0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_en = 1'b1; iot_in = 8'hF0; fn_sel = 3'd3;
      tick();
    end
    in_en = 1'b0;
    rst = 1'b1;
    #1;
    chk1("mid_rst busy", busy, 1'b1);
    chk1("mid_rst valid", valid, 1'b0);
    chk("mid_rst out", iot_out, '0);
    tick();
    rst = 1'b0;
    last_out = '0;
    chk1("post_rst idle busy", busy, 1'b1);
    tick();
    chk1("post_rst load busy", busy, 1'b0);
    for (int k = 0; k < 8; k++)
      run_block("avg_fresh", W'(10 * (k + 1)), 3'd3, (k == 7), 128'h2D, 1, 1'b0);

    in_en = 1'b0;
    repeat (4) begin
      tick();
      chk1("idle_tail valid", valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
